// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces a raw push-button pad into a
// clean active-high level. It also produces registered press/release strobes,
// a wrapping 8-bit press counter and an optional one-shot long-press strobe.
// Optional feature macro: BUTTON_LONG_PRESS_EN (builds hold_cnt/long_press;
// when undefined, long_press is tied to 0).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       long_press,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  localparam int             DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // Pad level seen while the button is not pressed.
  localparam logic           IDLE_PAD = ACTIVE_LOW;

  logic             sync_q1;
  logic             sync_q2;
  logic             sync;
  state_t           state;
  state_t           state_next;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_cnt_next;
  logic             level_next;

  // Two-flop synchronizer for the asynchronous pad, parked at the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= IDLE_PAD;
      sync_q2 <= IDLE_PAD;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  assign sync = ACTIVE_LOW ? ~sync_q2 : sync_q2;

  // State register and debounce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RELEASED;
      db_cnt <= '0;
    end else begin
      state  <= state_next;
      db_cnt <= db_cnt_next;
    end
  end

  // Next-state logic: a level change is accepted only after an unbroken run
  // of DEBOUNCE_CYCLES opposite samples; any contrary sample aborts the run.
  // The >= compare lets DEBOUNCE_CYCLES=1 leave a PEND state on the next cycle.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    case (state)
      RELEASED: begin
        if (sync) begin
          state_next  = PRESS_PEND;
          db_cnt_next = DB_ONE;
        end
      end
      PRESS_PEND: begin
        if (!sync) begin
          state_next  = RELEASED;
          db_cnt_next = '0;
        end else if (db_cnt >= DB_LAST) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_next  = RELEASE_PEND;
          db_cnt_next = DB_ONE;
        end
      end
      RELEASE_PEND: begin
        if (sync) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else if (db_cnt >= DB_LAST) begin
          state_next  = RELEASED;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + DB_ONE;
        end
      end
      default: begin
        state_next  = RELEASED;
        db_cnt_next = '0;
      end
    endcase
  end

  // Output decode: the button counts as pressed in PRESSED and RELEASE_PEND.
  always_comb begin
    level_next = (state_next == PRESSED) || (state_next == RELEASE_PEND);
  end

  // Registered level, edge strobes and press counter, updated with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= 8'd0;
    end else begin
      btn_level   <= level_next;
      btn_press   <= level_next & ~btn_level;
      btn_release <= ~level_next & btn_level;
      if (level_next && !btn_level) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;

  // Hold timer: fires long_press once and saturates until the level drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!btn_level) begin
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_LAST) begin
        hold_cnt   <= HOLD_SAT;
        long_press <= 1'b1;
      end else if (hold_cnt < HOLD_LAST) begin
        hold_cnt <= hold_cnt + HOLD_ONE;
      end
    end
  end
`else
  // Long-press support compiled out; constant 0 for any legal LONG_CYCLES.
  assign long_press = (LONG_CYCLES < 0);
`endif

endmodule
